// File: rtl/sublime_dpram_stream_reader_if.sv
// Output stream of the DPRAM window reader: valid/ready with a per-word last flag.
// A word transfers on a rising edge where m_valid & m_ready; m_data/m_last hold while m_valid & !m_ready.
interface sublime_dpram_stream_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/sublime_dpram_stream_reader.sv
// Sweeps an address window of a registered-read RAM and streams the words out
// through a 2-entry buffer, one word per cycle with full backpressure.
module sublime_dpram_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  loop,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  sublime_dpram_stream_reader_if.master m,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q, cnt_q, len_eff;
  logic                  loop_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic                  infl_q, infl_last_q;
  logic [DATA_WIDTH-1:0] h_data, s_data;
  logic                  h_last, s_last, h_valid, s_valid;
  logic                  done_q, done_d;
  logic                  pop, push, issue, issue_last, accept, flush;
  logic [2:0]            fill;

  assign len_eff = (length == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, length};
  assign pop     = h_valid & m.m_ready;
  assign push    = infl_q;
  // Projected occupancy after this edge, counting the word already in flight.
  assign fill    = 3'(h_valid) + 3'(s_valid) + 3'(infl_q) - 3'(pop);
  assign accept  = (state_q == IDLE) && start && !abort;
  assign flush   = (state_q != IDLE) && abort;

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          issue      = (fill < 3'd2);
          issue_last = issue && (cnt_q == 1);
          if (issue_last && !loop_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort || (!infl_q && !s_valid && (!h_valid || pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      loop_q      <= 1'b0;
      raddr_q     <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      infl_q      <= issue;
      infl_last_q <= issue_last;
      if (accept) begin
        base_q  <= base_addr;
        len_q   <= len_eff;
        cnt_q   <= len_eff;
        loop_q  <= loop;
        raddr_q <= base_addr;
      end else if (issue) begin
        if (issue_last) begin
          if (loop_q) begin
            raddr_q <= base_q;
            cnt_q   <= len_q;
          end
        end else begin
          raddr_q <= raddr_q + 1'b1;
          cnt_q   <= cnt_q - 1'b1;
        end
      end
    end
  end

  // Two-register buffer: h is the head driving the stream, s the overflow slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_data  <= '0;
      h_last  <= 1'b0;
      h_valid <= 1'b0;
      s_data  <= '0;
      s_last  <= 1'b0;
      s_valid <= 1'b0;
    end else if (flush) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
    end else begin
      case ({push, pop})
        2'b01: begin
          if (s_valid) begin
            h_data <= s_data;
            h_last <= s_last;
          end
          h_valid <= s_valid;
          s_valid <= 1'b0;
        end
        2'b10: begin
          if (!h_valid) begin
            h_data  <= rdata;
            h_last  <= infl_last_q;
            h_valid <= 1'b1;
          end else begin
            s_data  <= rdata;
            s_last  <= infl_last_q;
            s_valid <= 1'b1;
          end
        end
        2'b11: begin
          if (s_valid) begin
            h_data <= s_data;
            h_last <= s_last;
            s_data <= rdata;
            s_last <= infl_last_q;
          end else begin
            h_data <= rdata;
            h_last <= infl_last_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign raddr     = raddr_q;
  assign m.m_data  = h_data;
  assign m.m_valid = h_valid;
  assign m.m_last  = h_last & h_valid;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_sublime_dpram_stream_reader.sv
// Directed bench for the DPRAM stream reader: cycle-exact basic pass, wrap,
// backpressure, loop/abort, ignored starts and asynchronous reset.
module tb_sublime_dpram_stream_reader;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, loop;
  logic [AW-1:0] base_addr, length, raddr;
  logic [DW-1:0] rdata;
  logic          busy, done;
  logic [1:0]    state;

  sublime_dpram_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  sublime_dpram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop(loop),
    .base_addr(base_addr), .length(length), .raddr(raddr), .rdata(rdata),
    .m(bus.master), .busy(busy), .done(done), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM model: RAM[i] = i, one-cycle registered read
  logic [DW-1:0] ram [2**AW];
  initial for (int i = 0; i < 2**AW; i++) ram[i] = DW'(i);
  always @(posedge clk) rdata <= ram[raddr];

  // sink ready: 1 = always ready, 0 = random toggling
  int ready_mode = 1;
  always @(posedge clk) begin
    #1;
    bus.m_ready = (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: {last, data}
  logic [DW:0]   exp_q[$];
  logic          mon_en = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            hs_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.m_valid), 32'd1);
        check("stall_data", 32'(bus.m_data), 32'(prev_data));
      end
      if (bus.m_valid && bus.m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("extra_word", 32'd1, 32'd0);
        else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("word_data", 32'(bus.m_data), 32'(e[DW-1:0]));
          check("word_last", 32'(bus.m_last), 32'(e[DW]));
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // driver tasks
  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic lp);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l; loop = lp;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [AW-1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      exp_q.push_back({(i == n - 1), DW'(a)});
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; loop = 1'b0;
    base_addr = '0; length = '0;
    repeat (3) @(negedge clk);
    check("rst_raddr", 32'(raddr), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_last", 32'(bus.m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    rst_n = 1'b1;

    // basic pass, cycle exact: base=4 length=5
    do_start(8'd4, 8'd5, 1'b0);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      check("basic_busy", 32'(busy), 32'(cyc >= 1 && cyc <= 7));
      check("basic_valid", 32'(bus.m_valid), 32'(cyc >= 3 && cyc <= 7));
      if (cyc >= 3 && cyc <= 7) check("basic_data", 32'(bus.m_data), 32'(cyc + 1));
      check("basic_last", 32'(bus.m_last), 32'(cyc == 7));
      check("basic_done", 32'(done), 32'(cyc == 8));
      if (cyc == 1) check("basic_raddr", 32'(raddr), 32'd4);
    end

    // wrap past the top of the RAM
    mon_en = 1'b1;
    push_exp(8'hFE, 4);
    do_start(8'hFE, 8'd4, 1'b0);
    wait_done(100);
    check("wrap_drained", 32'(exp_q.size()), 32'd0);

    // 256-word pass under random backpressure
    ready_mode = 0;
    push_exp(8'h30, 256);
    do_start(8'h30, 8'd0, 1'b0);
    wait_done(3000);
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    ready_mode = 1;
    @(negedge clk);

    // loop, then abort mid-pass
    for (int i = 0; i < 30; i++) exp_q.push_back({(i % 3 == 2), DW'(10 + i % 3)});
    hs_cnt = 0;
    do_start(8'd10, 8'd3, 1'b1);
    for (int n = 0; n < 50 && hs_cnt < 7; n++) begin
      @(negedge clk);
      if (hs_cnt >= 1) check("loop_gap", 32'(bus.m_valid), 32'd1);
    end
    check("loop_words", 32'(hs_cnt), 32'd7);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(bus.m_valid), 32'd0);
    check("abort_done", 32'(done), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    @(negedge clk);
    check("abort_done_pulse", 32'(done), 32'd0);
    exp_q.delete();
    push_exp(8'h20, 2);
    do_start(8'h20, 8'd2, 1'b0);
    wait_done(100);
    check("post_abort_drained", 32'(exp_q.size()), 32'd0);

    // start while busy is ignored
    push_exp(8'h40, 6);
    do_start(8'h40, 8'd6, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h80; length = 8'd1; loop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    check("busy_start_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("busy_start_idle", 32'(busy), 32'd0);

    // abort + start together in IDLE: abort wins
    @(posedge clk); #1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_state", 32'(state), 32'd0);
    check("idle_abort_done", 32'(done), 32'd0);
    @(negedge clk);
    check("idle_abort_valid", 32'(bus.m_valid), 32'd0);

    // asynchronous reset mid-run
    mon_en = 1'b0;
    do_start(8'h50, 8'd8, 1'b0);
    for (int n = 0; n < 20 && !bus.m_valid; n++) @(negedge clk);
    check("ar_valid_before", 32'(bus.m_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_m_valid", 32'(bus.m_valid), 32'd0);
    check("ar_m_data", 32'(bus.m_data), 32'd0);
    check("ar_m_last", 32'(bus.m_last), 32'd0);
    check("ar_raddr", 32'(raddr), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_done", 32'(done), 32'd0);
    check("ar_state", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_no_done", 32'(done), 32'd0);
    exp_q.delete();
    mon_en = 1'b1;
    push_exp(8'h50, 3);
    do_start(8'h50, 8'd3, 1'b0);
    wait_done(100);
    check("ar_restart_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sublime_dpram_stream_reader.md
# sublime_dpram_stream_reader

Streaming read controller for the single-clock simple dual-port RAM. It sweeps a programmable address window of the RAM read port and turns the RAM's one-cycle registered read into a valid/ready stream with full backpressure, one word per cycle at full throughput. It is the consumer-side counterpart to the RAM's write port, used for wavetable and sample-buffer playback.

## Interface
- ADDR_WIDTH, 8, RAM address width; also the width of window base and length.
- DATA_WIDTH, 16, RAM and stream data width.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; begins a pass when idle.
- abort  in  1  single-cycle pulse; terminates the current run.
- loop  in  1  sampled with start; 1 = repeat the window until abort.
- base_addr  in  ADDR_WIDTH  first address of the window, sampled with start.
- length  in  ADDR_WIDTH  word count, sampled with start; 0 means 2^ADDR_WIDTH.
- raddr  out  ADDR_WIDTH  to RAM read address.
- rdata  in  DATA_WIDTH  from RAM read data; valid the cycle after raddr is issued.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready; a word transfers on m_valid & m_ready.
- m_last  out  1  marks the final word of each pass; qualified by m_valid.
- busy  out  1  high from the cycle after start is accepted until the run ends.
- done  out  1  one-cycle pulse at the end of a run.

## Operation
- States:
  - IDLE: waiting for a start pulse.
  - RUN: issuing reads.
  - DRAIN: all reads issued; waiting for the buffer to empty.
- IDLE->RUN on start (abort not set). base_addr, length and loop are latched at that edge; the issue counter is loaded with length (0 loads 2^ADDR_WIDTH).
- start while busy is ignored.
- Issue rule:
  - A read is issued in a cycle when state=RUN and (occupancy + inflight − pop) < 2, where pop = m_valid & m_ready.
  - raddr carries the issued address.
  - raddr is a register; it holds its last value when not issuing.
  - inflight is 0 or 1; the returning rdata is written to the buffer on the following edge.
- Output buffer: 2-entry FIFO. m_data/m_valid come from its head; m_last is stored per entry.
- Address arithmetic: the address increments modulo 2^ADDR_WIDTH, so the window may wrap past the top of the RAM.
- Pass end: the word issued when the remaining count reaches 1 is tagged last.
  - loop=0: RUN->DRAIN.
  - loop=1: the address reloads to base, the count reloads, and the state stays RUN. There is no bubble between passes.
- DRAIN->IDLE when the buffer and inflight are both empty. done pulses the cycle after the handshake of the last word.
- Abort, any state other than IDLE:
  - Issuing stops immediately.
  - Buffered and inflight data are discarded; m_valid is 0 from the next cycle.
  - State goes to IDLE and done pulses the next cycle.
  - Abort in IDLE has no effect. Abort together with start in IDLE: abort wins and start is ignored.
- m_data remains stable while m_valid=1 and m_ready=0.
- RAM contents are read-before-write: a same-cycle write to raddr returns the old data.

## Timing
- Reset values: raddr=0, m_data=0, m_valid=0, m_last=0, busy=0, done=0, state=IDLE.
- With start high in cycle 0:
  - busy=1 and raddr=base from cycle 1.
  - rdata is valid in cycle 2.
  - m_valid=1 in cycle 3.
- With m_ready held high: one word per cycle; N words finish handshaking in cycles 3..N+2; done=1 in cycle N+3; busy=0 in cycle N+3.
- Backpressure: at most 2 buffered words plus 0 inflight when stalled. Releasing m_ready resumes at full rate with no bubble.
- Reset asserted mid-run clears all state asynchronously. No done pulse is produced.

## Test plan
- Basic pass: RAM[i]=i, base=4, length=5, loop=0, m_ready=1 -> m_data 4,5,6,7,8 in cycles 3..7; m_last only on 8; done in cycle 8.
- Wrap: ADDR_WIDTH=8, base=0xFE, length=4 -> addresses FE,FF,00,01 in order; m_last on the word read from 0x01.
- Backpressure: m_ready toggled pseudo-randomly over length=0 (256 words) -> all 256 words delivered in order with no loss or duplication; m_data stable during stalls; inflight+occupancy never exceeds 2.
- Loop then abort: loop=1, length=3, base=10 -> 10,11,12(last),10,11,12(last),... with no gaps; abort mid-pass -> m_valid=0 next cycle, done pulse, busy=0; a new start after that works normally.
- Start while busy and abort+start in IDLE -> both starts ignored; no state change.
- Async reset mid-run with m_valid=1 -> all outputs 0 immediately; the first start after reset produces the correct data from base.
